// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : PC register, zero-latency instruction fetch and IF/ID register
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_adr,
  input  logic [31:0] imem_dout,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic        range_err,
  output logic [31:0] fetch_count
);

  localparam logic [29:0] C_DEPTH_WORDS = 30'(IMEM_DEPTH);
  localparam logic [31:0] C_NOP         = 32'h0000_0000;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  logic [31:0] w_pc_plus4;
  logic        w_out_of_range;
  logic        w_tgt_misaligned;

  assign w_pc_plus4       = pc_q + 32'd4;
  assign w_out_of_range   = (pc_q[31:2] >= C_DEPTH_WORDS);
  assign w_tgt_misaligned = (redirect_target[1:0] != 2'b00);

  // Priority: redirect > flush > out-of-range > stall > normal fetch.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    count_d    = count_q;

    if (redirect) begin
      pc_d    = {redirect_target[31:2], 2'b00};
      instr_d = C_NOP;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      if (w_tgt_misaligned) begin
        misalign_d = 1'b1;
      end
    end else if (flush || w_out_of_range) begin
      // PC is held so the same address is refetched once the bubble clears.
      instr_d = C_NOP;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = w_pc_plus4;
      instr_d = imem_dout;
      pc4_d   = w_pc_plus4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= C_NOP;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_adr     = pc_q;
  assign pc           = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign misalign_err = misalign_q;
  assign range_err    = w_out_of_range;
  assign fetch_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : directed self-checking bench for if_stage
// Rev 1.0     : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_if_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_adr;
  logic [31:0] imem_dout;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        misalign_err;
  logic        range_err;
  logic [31:0] fetch_count;

  logic [31:0] rom [256];

  int compared;
  int mismatched;

  if_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (256)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall           (stall),
    .flush           (flush),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_adr        (imem_adr),
    .imem_dout       (imem_dout),
    .pc              (pc),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .misalign_err    (misalign_err),
    .range_err       (range_err),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_dout = (imem_adr[31:10] == 22'd0) ? rom[imem_adr[9:2]] : 32'hDEAD_BEEF;

  function automatic logic [31:0] rom_word(input int idx);
    return 32'h2400_0000 | (32'(idx) * 32'd3 + 32'd1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic f, input logic r, input logic [31:0] t);
    stall           = s;
    flush           = f;
    redirect        = r;
    redirect_target = t;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 256; i++) rom[i] = rom_word(i);

    reset_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    #12;
    check("rst_pc",       pc,                  32'h0);
    check("rst_adr",      imem_adr,            32'h0);
    check("rst_valid",    {31'd0, if_id_valid}, 32'd0);
    check("rst_instr",    if_id_instr,         32'h0);
    check("rst_pc4",      if_id_pc4,           32'h0);
    check("rst_count",    fetch_count,         32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_range",    {31'd0, range_err},  32'd0);

    // Three normal fetches: A, B, C
    step();
    reset_n = 1'b1;
    step();
    check("f1_instr", if_id_instr, rom_word(0));
    check("f1_pc4",   if_id_pc4,   32'd4);
    check("f1_valid", {31'd0, if_id_valid}, 32'd1);
    step();
    check("f2_instr", if_id_instr, rom_word(1));
    check("f2_pc4",   if_id_pc4,   32'd8);
    step();
    check("f3_instr", if_id_instr, rom_word(2));
    check("f3_pc4",   if_id_pc4,   32'd12);
    check("f3_pc",    pc,          32'd12);
    check("f3_count", fetch_count, 32'd3);

    // Asynchronous reset between edges from a running state
    #2;
    reset_n = 1'b0;
    #1;
    check("arst1_pc",    pc,          32'h0);
    check("arst1_count", fetch_count, 32'd0);
    check("arst1_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    reset_n = 1'b1;

    // A latched, then stall for two edges, then B
    step();
    check("a_instr", if_id_instr, rom_word(0));
    check("a_pc",    pc,          32'd4);
    set_in(1'b1, 1'b0, 1'b0, 32'd0);
    step();
    check("st1_pc",    pc,          32'd4);
    check("st1_instr", if_id_instr, rom_word(0));
    step();
    check("st2_pc",    pc,          32'd4);
    check("st2_instr", if_id_instr, rom_word(0));
    check("st2_pc4",   if_id_pc4,   32'd4);
    check("st2_count", fetch_count, 32'd1);
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check("b_instr", if_id_instr, rom_word(1));
    check("b_pc",    pc,          32'd8);
    check("b_count", fetch_count, 32'd2);

    // Redirect wins over stall and flush
    set_in(1'b1, 1'b1, 1'b1, 32'h40);
    step();
    check("rd_pc",    pc,          32'h40);
    check("rd_valid", {31'd0, if_id_valid}, 32'd0);
    check("rd_instr", if_id_instr, 32'h0);
    check("rd_count", fetch_count, 32'd2);
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check("rd_n_instr", if_id_instr, rom_word(16));
    check("rd_n_pc4",   if_id_pc4,   32'h44);
    check("rd_n_count", fetch_count, 32'd3);

    // Flush with stall: bubble, PC held, same word refetched afterwards
    set_in(1'b1, 1'b1, 1'b0, 32'd0);
    step();
    check("fl_valid", {31'd0, if_id_valid}, 32'd0);
    check("fl_pc4",   if_id_pc4,   32'h0);
    check("fl_pc",    pc,          32'h44);
    check("fl_count", fetch_count, 32'd3);
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check("fl_n_instr", if_id_instr, rom_word(17));
    check("fl_n_pc4",   if_id_pc4,   32'h48);
    check("fl_n_count", fetch_count, 32'd4);

    // Misaligned redirect, then run off the end of the memory
    set_in(1'b0, 1'b0, 1'b1, 32'h3FE);
    step();
    check("mis_pc",   pc, 32'h3FC);
    check("mis_flag", {31'd0, misalign_err}, 32'd1);
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check("last_instr", if_id_instr, rom_word(255));
    check("last_pc4",   if_id_pc4,   32'h400);
    check("last_pc",    pc,          32'h400);
    check("last_range", {31'd0, range_err}, 32'd1);
    check("last_count", fetch_count, 32'd5);
    step();
    check("oor_valid", {31'd0, if_id_valid}, 32'd0);
    check("oor_instr", if_id_instr, 32'h0);
    check("oor_pc",    pc,          32'h400);
    check("oor_count", fetch_count, 32'd5);
    set_in(1'b1, 1'b0, 1'b0, 32'd0);
    step();
    check("oor_st_pc",    pc,          32'h400);
    check("oor_st_count", fetch_count, 32'd5);
    check("oor_st_range", {31'd0, range_err}, 32'd1);

    set_in(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    check("back_range",    {31'd0, range_err},    32'd0);
    check("back_pc",       pc,                    32'h0);
    check("back_misalign", {31'd0, misalign_err}, 32'd1);

    // Bring PC to 0x20 with a live instruction, then async reset
    set_in(1'b0, 1'b0, 1'b1, 32'h1C);
    step();
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check("p20_pc",    pc,          32'h20);
    check("p20_instr", if_id_instr, rom_word(7));
    check("p20_valid", {31'd0, if_id_valid}, 32'd1);
    check("p20_count", fetch_count, 32'd6);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst2_pc",       pc, 32'h0);
    check("arst2_valid",    {31'd0, if_id_valid},  32'd0);
    check("arst2_misalign", {31'd0, misalign_err}, 32'd0);
    check("arst2_count",    fetch_count, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("post_instr", if_id_instr, rom_word(0));
    check("post_pc4",   if_id_pc4,   32'd4);
    check("post_count", fetch_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_DEPTH, default 256: instruction memory size in 32-bit words.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1: hold PC and IF/ID register.
REQ-006 SHALL have port flush  input  1: replace the IF/ID contents with a bubble.
REQ-007 SHALL have port redirect  input  1: load the PC from redirect_target (branch/jump/jr).
REQ-008 SHALL have port redirect_target  input  32: byte address of the redirect target.
REQ-009 SHALL have port imem_adr  output  32: byte address to the instruction ROM; ROM indexes words with imem_adr[31:2].
REQ-010 SHALL have port imem_dout  input  32: instruction returned combinationally by the ROM.
REQ-011 SHALL have port pc  output  32: current fetch PC.
REQ-012 SHALL have port if_id_instr  output  32: registered instruction.
REQ-013 SHALL have port if_id_pc4  output  32: registered PC+4 of that instruction.
REQ-014 SHALL have port if_id_valid  output  1: IF/ID holds a real instruction.
REQ-015 SHALL have port misalign_err  output  1: sticky flag, a redirect target had nonzero bits [1:0].
REQ-016 SHALL have port range_err  output  1: the PC is outside the instruction memory.
REQ-017 SHALL have port fetch_count  output  32: number of instructions written into IF/ID.

Function
REQ-018 SHALL drive imem_adr = pc combinationally, so the instruction is fetched in the same cycle as the PC (zero-cycle ROM).
REQ-019 SHALL assert range_err combinationally whenever pc[31:2] >= IMEM_DEPTH.
REQ-020 SHALL apply the per-edge update in this priority order: redirect, flush, range_err, stall, normal.
REQ-021 Redirect: SHALL load pc <= {redirect_target[31:2],2'b00} and load an IF/ID bubble, regardless of stall or flush.
REQ-022 Redirect with redirect_target[1:0] != 0: SHALL also set misalign_err; misalign_err SHALL clear only on reset.
REQ-023 Flush without redirect: SHALL load an IF/ID bubble and hold pc, so the same address is refetched; this applies even when stall is asserted.
REQ-024 range_err without redirect or flush: SHALL load an IF/ID bubble and hold pc; range_err SHALL clear only through a redirect to an in-range address, or through reset.
REQ-025 Stall alone: SHALL hold pc, if_id_instr, if_id_pc4 and if_id_valid unchanged.
REQ-026 Normal: SHALL load if_id_instr <= imem_dout, if_id_pc4 <= pc+4, if_id_valid <= 1, and pc <= pc+4.
REQ-027 Bubble definition: if_id_instr = 32'h0000_0000 (MIPS nop), if_id_pc4 = 0, if_id_valid = 0.
REQ-028 PC+4 SHALL be 32-bit modulo arithmetic: 32'hFFFF_FFFC + 4 = 0.
REQ-029 SHALL increment fetch_count by 1 only on a normal update (REQ-026); it wraps from 32'hFFFF_FFFF to 0.

Reset
REQ-030 While reset_n = 0, independent of clk, SHALL force pc = RESET_PC, the IF/ID register to a bubble, misalign_err = 0 and fetch_count = 0.
REQ-031 When reset_n is released mid-operation, the first normal edge SHALL fetch RESET_PC; no state from before reset SHALL survive.

Verification
REQ-032 ROM words 0..3 = A,B,C,D; release reset; 3 normal edges -> if_id_instr = A, B, C in turn, if_id_pc4 = 4, 8, 12, pc = 12, fetch_count = 3.
REQ-033 Stall for 2 edges after A is latched -> pc = 4 and if_id_instr = A throughout, fetch_count unchanged; release -> B latched.
REQ-034 redirect = 1, target = 0x40, together with stall = 1 and flush = 1 -> pc = 0x40, if_id_valid = 0; next normal edge latches ROM word 16 with if_id_pc4 = 0x44.
REQ-035 redirect to 0x3FE -> pc = 0x3FC, misalign_err = 1, and it stays 1 after a later redirect to 0x0; then redirect to 0x400 with IMEM_DEPTH = 256 -> range_err = 1, bubbles inserted, pc held at 0x400, fetch_count frozen; redirect to 0x0 -> range_err = 0.
REQ-036 Assert reset_n = 0 between clock edges with pc = 0x20 -> pc = RESET_PC and if_id_valid = 0 immediately, without a clock edge.
